// File: rtl/register_file.sv
// Architectural register file with per-register rename state (busy + ROB tag); x0 reads as zero.
// Reads are combinational, with a same-cycle commit bypass; updates land on the next edge.
// No backpressure: rdy_in=0 freezes all state and disables the bypass. REGFILE_DEBUG_EN adds a debug read port.
module register_file #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ROB_AW = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              dispatch_en_in,
    input  logic [REG_AW-1:0] rs1_in,
    input  logic [REG_AW-1:0] rs2_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [ROB_AW-1:0] rd_robnum_in,
    output logic [XLEN-1:0]   rs1_data_out,
    output logic              rs1_busy_out,
    output logic [ROB_AW-1:0] rs1_robnum_out,
    output logic [XLEN-1:0]   rs2_data_out,
    output logic              rs2_busy_out,
    output logic [ROB_AW-1:0] rs2_robnum_out,
    input  logic              commit_en_in,
    input  logic [REG_AW-1:0] commit_rd_in,
    input  logic [ROB_AW-1:0] commit_robnum_in,
    input  logic [XLEN-1:0]   commit_data_in,
    input  logic              flush_in
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [REG_AW-1:0] dbg_sel_in,
    output logic [XLEN-1:0]   dbg_data_out
`endif
);

    localparam int NREG = 1 << REG_AW;

    logic [XLEN-1:0]   data_q [NREG];
    logic              busy_q [NREG];
    logic [ROB_AW-1:0] tag_q  [NREG];

    // Commit targets a real register; only clears rename state when its tag is still current.
    logic commit_vld;
    assign commit_vld = commit_en_in && (commit_rd_in != '0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                busy_q[r] <= 1'b0;
                tag_q[r]  <= '0;
            end
        end else if (rdy_in) begin
            for (int r = 1; r < NREG; r++) begin
                if (commit_vld && commit_rd_in == REG_AW'(r))
                    data_q[r] <= commit_data_in;
                if (flush_in) begin
                    busy_q[r] <= 1'b0;
                    tag_q[r]  <= '0;
                end else if (dispatch_en_in && rd_in == REG_AW'(r)) begin
                    // A new rename outranks a same-cycle commit to the same register.
                    busy_q[r] <= 1'b1;
                    tag_q[r]  <= rd_robnum_in;
                end else if (commit_vld && commit_rd_in == REG_AW'(r) &&
                             tag_q[r] == commit_robnum_in) begin
                    busy_q[r] <= 1'b0;
                    tag_q[r]  <= '0;
                end
            end
        end
    end

    logic rs1_byp, rs2_byp;
    assign rs1_byp = rdy_in && commit_en_in && commit_rd_in == rs1_in && rs1_in != '0 &&
                     busy_q[rs1_in] && tag_q[rs1_in] == commit_robnum_in;
    assign rs2_byp = rdy_in && commit_en_in && commit_rd_in == rs2_in && rs2_in != '0 &&
                     busy_q[rs2_in] && tag_q[rs2_in] == commit_robnum_in;

    always_comb begin
        rs1_data_out   = '0;
        rs1_busy_out   = 1'b0;
        rs1_robnum_out = '0;
        if (rs1_byp) begin
            rs1_data_out = commit_data_in;
        end else if (rs1_in != '0) begin
            rs1_data_out   = data_q[rs1_in];
            rs1_busy_out   = busy_q[rs1_in];
            rs1_robnum_out = tag_q[rs1_in];
        end
    end

    always_comb begin
        rs2_data_out   = '0;
        rs2_busy_out   = 1'b0;
        rs2_robnum_out = '0;
        if (rs2_byp) begin
            rs2_data_out = commit_data_in;
        end else if (rs2_in != '0) begin
            rs2_data_out   = data_q[rs2_in];
            rs2_busy_out   = busy_q[rs2_in];
            rs2_robnum_out = tag_q[rs2_in];
        end
    end

`ifdef REGFILE_DEBUG_EN
    assign dbg_data_out = data_q[dbg_sel_in];
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, rename, bypass, stale commit, collision, flush, x0, hold.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        dispatch_en_in;
    logic [4:0]  rs1_in, rs2_in, rd_in, commit_rd_in;
    logic [3:0]  rd_robnum_in, commit_robnum_in;
    logic [31:0] commit_data_in;
    logic        commit_en_in, flush_in;
    logic [31:0] rs1_data_out, rs2_data_out;
    logic        rs1_busy_out, rs2_busy_out;
    logic [3:0]  rs1_robnum_out, rs2_robnum_out;
`ifdef REGFILE_DEBUG_EN
    logic [4:0]  dbg_sel_in = '0;
    logic [31:0] dbg_data_out;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    register_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dispatch_en_in(dispatch_en_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .rd_in(rd_in), .rd_robnum_in(rd_robnum_in),
        .rs1_data_out(rs1_data_out), .rs1_busy_out(rs1_busy_out), .rs1_robnum_out(rs1_robnum_out),
        .rs2_data_out(rs2_data_out), .rs2_busy_out(rs2_busy_out), .rs2_robnum_out(rs2_robnum_out),
        .commit_en_in(commit_en_in), .commit_rd_in(commit_rd_in),
        .commit_robnum_in(commit_robnum_in), .commit_data_in(commit_data_in),
        .flush_in(flush_in)
`ifdef REGFILE_DEBUG_EN
        , .dbg_sel_in(dbg_sel_in), .dbg_data_out(dbg_data_out)
`endif
    );

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        dispatch_en_in = 0; rd_in = 0; rd_robnum_in = 0;
        commit_en_in = 0; commit_rd_in = 0; commit_robnum_in = 0; commit_data_in = 0;
        flush_in = 0;
    endtask

    task automatic test_reset();
        rst_in = 1; rdy_in = 1; rs1_in = 5; rs2_in = 6; idle();
        #3;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== 37'h0) begin
            errors++; $display("FAIL reset_rs1 got=%h want=0", {rs1_data_out, rs1_busy_out, rs1_robnum_out});
        end
        tick(); rst_in = 0; tick();
        commit_en_in = 1; commit_rd_in = 5; commit_data_in = 7;
        tick(); idle();
        dispatch_en_in = 1; rd_in = 6; rd_robnum_in = 3;
        tick(); idle(); #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'd7, 1'b0, 4'd0}) begin
            errors++; $display("FAIL pre_reset_x5 got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'd7, 1'b0, 4'd0});
        end
        checks++;
        if ({rs2_busy_out, rs2_robnum_out} !== {1'b1, 4'd3}) begin
            errors++; $display("FAIL pre_reset_x6 got=%h want=%h", {rs2_busy_out, rs2_robnum_out}, {1'b1, 4'd3});
        end
        #1 rst_in = 1; #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== 37'h0) begin
            errors++; $display("FAIL midreset_x5 got=%h want=0", {rs1_data_out, rs1_busy_out, rs1_robnum_out});
        end
        checks++;
        if ({rs2_data_out, rs2_busy_out, rs2_robnum_out} !== 37'h0) begin
            errors++; $display("FAIL midreset_x6 got=%h want=0", {rs2_data_out, rs2_busy_out, rs2_robnum_out});
        end
        #1 rst_in = 0;
        tick();
    endtask

    task automatic test_rename();
        idle(); rs1_in = 3; rs2_in = 0;
        dispatch_en_in = 1; rd_in = 3; rd_robnum_in = 2; #1;
        checks++;
        if ({rs1_busy_out, rs1_robnum_out} !== 5'h0) begin
            errors++; $display("FAIL rename_same_cycle got=%h want=0", {rs1_busy_out, rs1_robnum_out});
        end
        tick(); idle(); #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'd0, 1'b1, 4'd2}) begin
            errors++; $display("FAIL rename_lookup got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'd0, 1'b1, 4'd2});
        end
    endtask

    task automatic test_bypass();
        idle(); rs1_in = 3; rs2_in = 3;
        commit_en_in = 1; commit_rd_in = 3; commit_robnum_in = 2; commit_data_in = 32'hDEAD;
        rdy_in = 0; #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'd0, 1'b1, 4'd2}) begin
            errors++; $display("FAIL bypass_gated got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'd0, 1'b1, 4'd2});
        end
        tick(); rdy_in = 1; #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'hDEAD, 1'b0, 4'd0}) begin
            errors++; $display("FAIL bypass_rs1 got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'hDEAD, 1'b0, 4'd0});
        end
        checks++;
        if ({rs2_data_out, rs2_busy_out, rs2_robnum_out} !== {32'hDEAD, 1'b0, 4'd0}) begin
            errors++; $display("FAIL bypass_rs2 got=%h want=%h", {rs2_data_out, rs2_busy_out, rs2_robnum_out}, {32'hDEAD, 1'b0, 4'd0});
        end
        tick(); idle(); #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'hDEAD, 1'b0, 4'd0}) begin
            errors++; $display("FAIL bypass_stored got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'hDEAD, 1'b0, 4'd0});
        end
    endtask

    task automatic test_stale_commit();
        idle(); rs1_in = 3;
        dispatch_en_in = 1; rd_in = 3; rd_robnum_in = 2; tick();
        rd_robnum_in = 5; tick(); idle();
        commit_en_in = 1; commit_rd_in = 3; commit_robnum_in = 2; commit_data_in = 9; #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'hDEAD, 1'b1, 4'd5}) begin
            errors++; $display("FAIL stale_no_bypass got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'hDEAD, 1'b1, 4'd5});
        end
        tick(); idle(); #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'd9, 1'b1, 4'd5}) begin
            errors++; $display("FAIL stale_commit got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'd9, 1'b1, 4'd5});
        end
    endtask

    task automatic test_collision();
        idle(); rs1_in = 4;
        dispatch_en_in = 1; rd_in = 4; rd_robnum_in = 1; tick();
        rd_robnum_in = 6;
        commit_en_in = 1; commit_rd_in = 4; commit_robnum_in = 1; commit_data_in = 11; #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'd11, 1'b0, 4'd0}) begin
            errors++; $display("FAIL collision_bypass got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'd11, 1'b0, 4'd0});
        end
        tick(); idle(); #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== {32'd11, 1'b1, 4'd6}) begin
            errors++; $display("FAIL collision got=%h want=%h", {rs1_data_out, rs1_busy_out, rs1_robnum_out}, {32'd11, 1'b1, 4'd6});
        end
    endtask

    task automatic test_flush_x0();
        idle();
        for (int r = 1; r < 32; r++) begin
            dispatch_en_in = 1; rd_in = 5'(r); rd_robnum_in = 4'((r % 15) + 1);
            tick();
        end
        idle(); rs1_in = 9; #1;
        checks++;
        if ({rs1_busy_out, rs1_robnum_out} !== {1'b1, 4'd10}) begin
            errors++; $display("FAIL preflush_x9 got=%h want=%h", {rs1_busy_out, rs1_robnum_out}, {1'b1, 4'd10});
        end
        flush_in = 1; commit_en_in = 1; commit_rd_in = 7; commit_robnum_in = 3; commit_data_in = 3;
        dispatch_en_in = 1; rd_in = 8; rd_robnum_in = 4;
        tick(); idle();
        for (int r = 0; r < 32; r++) begin
            rs1_in = 5'(r); #1;
            checks++;
            if ({rs1_busy_out, rs1_robnum_out} !== 5'h0) begin
                errors++; $display("FAIL flush_busy x%0d got=%h want=0", r, {rs1_busy_out, rs1_robnum_out});
            end
        end
        rs1_in = 7; #1;
        checks++;
        if (rs1_data_out !== 32'd3) begin
            errors++; $display("FAIL flush_commit_x7 got=%h want=3", rs1_data_out);
        end
        dispatch_en_in = 1; rd_in = 0; rd_robnum_in = 5;
        commit_en_in = 1; commit_rd_in = 0; commit_data_in = 32'h55;
        tick(); idle(); rs1_in = 0; rs2_in = 0; #1;
        checks++;
        if ({rs1_data_out, rs1_busy_out, rs1_robnum_out} !== 37'h0) begin
            errors++; $display("FAIL x0 got=%h want=0", {rs1_data_out, rs1_busy_out, rs1_robnum_out});
        end
    endtask

    task automatic test_hold();
        idle(); rs1_in = 10; rdy_in = 0;
        dispatch_en_in = 1; rd_in = 10; rd_robnum_in = 7;
        commit_en_in = 1; commit_rd_in = 11; commit_data_in = 32'h77;
        tick(); idle(); rdy_in = 1; rs2_in = 11; #1;
        checks++;
        if ({rs1_busy_out, rs1_robnum_out} !== 5'h0) begin
            errors++; $display("FAIL hold_rename got=%h want=0", {rs1_busy_out, rs1_robnum_out});
        end
        checks++;
        if (rs2_data_out !== 32'd0) begin
            errors++; $display("FAIL hold_commit got=%h want=0", rs2_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_rename();
        test_bypass();
        test_stale_commit();
        test_collision();
        test_flush_x0();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
